// File: rtl/stop_watch_lap_mem_pkg.sv
// Shared types and limits for the stopwatch timer blocks.
package stop_watch_lap_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_e;

  localparam int FIELD_W = 7;
  localparam int LAP_W   = 3 * FIELD_W;

  localparam logic [FIELD_W-1:0] C_SEC_MAX = 7'd99;
  localparam logic [FIELD_W-1:0] SEC_MAX   = 7'd59;

  typedef struct packed {
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
    logic [FIELD_W-1:0] c_sec;
  } lap_word_t;

endpackage

// File: rtl/stop_watch_lap_mem_tick_divider.sv
// Free-running prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module tick_divider #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count holds while disabled so a resume finishes the partial tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (tick)  cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/stop_watch_lap_mem.sv
// Min/sec/centisecond stopwatch with a lap ring buffer and lap recall browsing.
module stop_watch_lap_mem
  import stop_watch_lap_mem_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int LAP_DEPTH   = 8,
  parameter int MAX_MIN     = 99,
  localparam int IDX_W      = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
  localparam int CNT_W      = $clog2(LAP_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_stop,
  input  logic               lap,
  input  logic               clear,
  input  logic               view_next,
  output logic [FIELD_W-1:0] fnd_min,
  output logic [FIELD_W-1:0] fnd_sec,
  output logic [FIELD_W-1:0] fnd_c_sec,
  output logic               running,
  output logic               recall,
  output logic [IDX_W-1:0]   view_idx,
  output logic [CNT_W-1:0]   lap_count,
  output logic               overflow
);

  localparam logic [FIELD_W-1:0] MIN_LIMIT = FIELD_W'(MAX_MIN);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(LAP_DEPTH);

  sw_state_e  state, state_nxt;
  lap_word_t  live, shown;
  lap_word_t  mem [LAP_DEPTH];
  logic [IDX_W-1:0] wr_ptr, rd_idx;
  logic       tick, run_en, clear_acc, lap_we, view_acc;

  assign run_en  = (state == RUN);
  assign running = run_en;

  tick_divider #(.TICK_DIV(CLK_FREQ_HZ / TICK_HZ)) u_tick_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_en),
    .clr     (clear_acc),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_acc = 1'b0;
    lap_we    = 1'b0;
    case (state)
      IDLE: begin
        if (clear)           clear_acc = 1'b1;
        else if (start_stop) state_nxt = RUN;
      end
      RUN: begin
        lap_we = lap;
        if (start_stop) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (clear) begin
          clear_acc = 1'b1;
          state_nxt = IDLE;
        end else if (start_stop) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
    view_acc = view_next && !lap_we && (lap_count != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (clear_acc) begin
        live <= '0;
      end else if (tick) begin
        if (live.c_sec != C_SEC_MAX) begin
          live.c_sec <= live.c_sec + 1'b1;
        end else begin
          live.c_sec <= '0;
          if (live.sec != SEC_MAX) begin
            live.sec <= live.sec + 1'b1;
          end else begin
            live.sec <= '0;
            if (live.min != MIN_LIMIT) begin
              live.min <= live.min + 1'b1;
            end else begin
              live.min <= '0;
              overflow <= 1'b1;
            end
          end
        end
      end
    end
  end

  // A lap stores the pre-increment time since live is the registered value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      recall    <= 1'b0;
      view_idx  <= '0;
    end else if (clear_acc) begin
      for (int unsigned i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      recall    <= 1'b0;
      view_idx  <= '0;
    end else if (lap_we) begin
      mem[wr_ptr] <= live;
      wr_ptr      <= (LAP_DEPTH == 1) ? '0 : wr_ptr + 1'b1;
      if (lap_count != CNT_FULL) lap_count <= lap_count + 1'b1;
      view_idx    <= '0;
    end else if (view_acc) begin
      if (!recall) begin
        recall   <= 1'b1;
        view_idx <= '0;
      end else if ((CNT_W'(view_idx) + 1'b1) < lap_count) begin
        view_idx <= view_idx + 1'b1;
      end else begin
        recall   <= 1'b0;
        view_idx <= '0;
      end
    end
  end

  always_comb begin
    rd_idx = (LAP_DEPTH == 1) ? '0 : (wr_ptr - 1'b1 - view_idx);
    shown  = recall ? mem[rd_idx] : live;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fnd_min   <= '0;
      fnd_sec   <= '0;
      fnd_c_sec <= '0;
    end else begin
      fnd_min   <= shown.min;
      fnd_sec   <= shown.sec;
      fnd_c_sec <= shown.c_sec;
    end
  end

endmodule

// File: tb/tb_stop_watch_lap_mem.sv
// Bench for stop_watch_lap_mem: DUT a (TICK_DIV=10, 4 laps) and DUT b (TICK_DIV=2, MAX_MIN=1).
module tb_stop_watch_lap_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start_stop, lap, clear, view_next;
  logic [6:0] fnd_min, fnd_sec, fnd_c_sec;
  logic       running, recall, overflow;
  logic [1:0] view_idx;
  logic [2:0] lap_count;

  logic       b_start_stop;
  logic [6:0] b_min, b_sec, b_csec;
  logic       b_running, b_recall, b_overflow;
  logic [1:0] b_view_idx;
  logic [2:0] b_lap_count;

  stop_watch_lap_mem #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .LAP_DEPTH   (4),
    .MAX_MIN     (99)
  ) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .view_next  (view_next),
    .fnd_min    (fnd_min),
    .fnd_sec    (fnd_sec),
    .fnd_c_sec  (fnd_c_sec),
    .running    (running),
    .recall     (recall),
    .view_idx   (view_idx),
    .lap_count  (lap_count),
    .overflow   (overflow)
  );

  stop_watch_lap_mem #(
    .CLK_FREQ_HZ (200),
    .TICK_HZ     (100),
    .LAP_DEPTH   (4),
    .MAX_MIN     (1)
  ) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (b_start_stop),
    .lap        (1'b0),
    .clear      (1'b0),
    .view_next  (1'b0),
    .fnd_min    (b_min),
    .fnd_sec    (b_sec),
    .fnd_c_sec  (b_csec),
    .running    (b_running),
    .recall     (b_recall),
    .view_idx   (b_view_idx),
    .lap_count  (b_lap_count),
    .overflow   (b_overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Bench model of DUT a: r = clock edges spent in RUN since the last clear/reset.
  bit m_run = 1'b0;
  int r = 0;
  int r_prev = 0;
  int laps[$];

  typedef struct {
    string name;
    int    m;
    int    s;
    int    c;
  } disp_t;
  disp_t sb[$];

  typedef struct {
    bit vn;
    bit lp;
    int e_recall;
    int e_vidx;
    int e_csec;   // -1: live time expected
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit ss, input bit lp, input bit cl, input bit vn);
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    view_next  = vn;
    @(negedge clk);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    view_next  = 1'b0;
    r_prev = r;
    if (cl && !m_run) begin
      r = 0;
      laps.delete();
    end else begin
      if (m_run) r++;
      if (lp && m_run) laps.push_back(r_prev / 10);
      if (ss) m_run = !m_run;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_disp(input string name, input int m, input int s, input int c);
    disp_t d;
    d.name = name; d.m = m; d.s = s; d.c = c;
    sb.push_back(d);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      d = sb.pop_front();
      chk({d.name, "_min"}, int'(fnd_min), d.m);
      chk({d.name, "_sec"}, int'(fnd_sec), d.s);
      chk({d.name, "_csec"}, int'(fnd_c_sec), d.c);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_min"}, int'(fnd_min), 0);
    chk({tag, "_sec"}, int'(fnd_sec), 0);
    chk({tag, "_csec"}, int'(fnd_c_sec), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_recall"}, int'(recall), 0);
    chk({tag, "_view_idx"}, int'(view_idx), 0);
    chk({tag, "_lap_count"}, int'(lap_count), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic chk_b_time(input string tag, input int t);
    chk({tag, "_min"}, int'(b_min), (t / 6000) % 2);
    chk({tag, "_sec"}, int'(b_sec), (t / 100) % 60);
    chk({tag, "_csec"}, int'(b_csec), t % 100);
  endtask

  initial begin
    int nb;
    int ov_cycles;

    vt[0] = '{vn: 1'b1, lp: 1'b0, e_recall: 1, e_vidx: 0, e_csec: 11};
    vt[1] = '{vn: 1'b1, lp: 1'b0, e_recall: 1, e_vidx: 1, e_csec: 9};
    vt[2] = '{vn: 1'b1, lp: 1'b0, e_recall: 1, e_vidx: 2, e_csec: 7};
    vt[3] = '{vn: 1'b1, lp: 1'b0, e_recall: 1, e_vidx: 3, e_csec: 5};
    vt[4] = '{vn: 1'b1, lp: 1'b0, e_recall: 0, e_vidx: 0, e_csec: -1};

    start_stop = 1'b0; lap = 1'b0; clear = 1'b0; view_next = 1'b0;
    b_start_stop = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    chk_zero("post_reset");

    // Run 10 ticks, pause, hold.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(101);
    chk("run10_csec", int'(fnd_c_sec), r_prev / 10);
    chk("run10_csec_abs", int'(fnd_c_sec), 10);
    chk("run10_running", int'(running), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(50);
    chk("pause_csec", int'(fnd_c_sec), 10);
    chk("pause_sec", int'(fnd_sec), 0);
    chk("pause_running", int'(running), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_in_pause", int'(lap_count), 0);

    // Clear ignored while running, accepted in pause.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_in_run_running", int'(running), 1);
    idle(20);
    chk("clear_in_run_csec", int'(fnd_c_sec), r_prev / 10);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clear_running", int'(running), 0);
    expect_disp("clear_disp", 0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_in_idle", int'(lap_count), 0);

    // Five laps into a four-entry buffer.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle((3 + 2 * k) * 10 + 4 - r);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("lap_count_%0d", k), int'(lap_count), (k < 4) ? k + 1 : 4);
    end

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, vt[i].lp, 1'b0, vt[i].vn);
      chk($sformatf("vec%0d_recall", i), int'(recall), vt[i].e_recall);
      chk($sformatf("vec%0d_view_idx", i), int'(view_idx), vt[i].e_vidx);
      expect_disp($sformatf("vec%0d", i), 0, 0, (vt[i].e_csec < 0) ? r / 10 : vt[i].e_csec);
    end

    // start_stop + lap at c_sec 20, then recall and lap/view interplay.
    idle(204 - r);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ss_lap_running", int'(running), 0);
    chk("ss_lap_count", int'(lap_count), 4);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_disp("ss_lap_stored", 0, 0, 20);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("view1_idx", int'(view_idx), 1);
    expect_disp("view1", 0, 0, 11);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_forces_view0", int'(view_idx), 0);
    chk("lap_keeps_recall", int'(recall), 1);
    expect_disp("lap_newest", 0, 0, laps[laps.size() - 1]);
    idle(20);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("vn_lap_view_idx", int'(view_idx), 0);
    chk("vn_lap_recall", int'(recall), 1);
    expect_disp("vn_lap_newest", 0, 0, 22);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_disp("vn_after", 0, 0, laps[laps.size() - 2]);

    // Asynchronous reset mid-count with recall active.
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    m_run = 1'b0; r = 0; r_prev = 0; laps.delete();
    idle(3);
    chk_zero("after_release");
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(15);
    chk("restart_csec", int'(fnd_c_sec), 1);
    chk("restart_min", int'(fnd_min), 0);

    // Clear drops stored laps and recall.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_lap", int'(lap_count), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("lap_in_pause2", int'(lap_count), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("recall_in_pause", int'(recall), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    expect_disp("clear_laps_disp", 0, 0, 0);
    chk_zero("clear_laps");

    // DUT b: minute carry and MAX_MIN wrap with one-cycle overflow.
    b_start_stop = 1'b1;
    @(negedge clk);
    b_start_stop = 1'b0;
    nb = 0;
    ov_cycles = 0;
    while (nb < 24010) begin
      @(negedge clk);
      nb++;
      if (b_overflow) ov_cycles++;
      case (nb)
        12000: chk_b_time("b_005999", (nb - 1) / 2);
        12001: chk_b_time("b_010000", 6000);
        23999: begin
          chk_b_time("b_015999", 11999);
          chk("b_ovf_before", int'(b_overflow), 0);
        end
        24000: chk("b_ovf_pulse", int'(b_overflow), 1);
        24001: begin
          chk("b_ovf_after", int'(b_overflow), 0);
          chk_b_time("b_wrap", 0);
        end
        24005: chk("b_running", int'(b_running), 1);
        default: ;
      endcase
    end
    chk("b_ovf_cycles", ov_cycles, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
